// File: rtl/cmd_pkg.sv
// Constants shared between the command-frame assembler and the command sequencer:
// frame layout, opcodes, response codes and the sequencer state encoding.
package cmd_pkg;

    localparam int FRAME_W   = 32;
    localparam int OP_LSB    = 26;
    localparam int OP_W      = 6;
    localparam int ADDR_LSB  = 8;
    localparam int DATA_LSB  = 0;
    localparam int DATA_W    = 8;

    localparam logic [OP_W-1:0] OP_INIT  = 6'h00;
    localparam logic [OP_W-1:0] OP_WRITE = 6'h01;
    localparam logic [OP_W-1:0] OP_READ  = 6'h02;

    localparam logic [7:0] RESP_INIT    = 8'hA5;
    localparam logic [7:0] RESP_WRITE   = 8'h5A;
    localparam logic [7:0] RESP_ILLEGAL = 8'hEE;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_ARB,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RESPOND
    } state_t;

    function automatic logic op_is_access(input logic [OP_W-1:0] op);
        return (op == OP_WRITE) || (op == OP_READ);
    endfunction

endpackage

// File: rtl/mem_timer.sv
// Loadable down-counter timing the strobe and hold intervals of an SRAM access.
// done is high while the count sits at zero, i.e. on the last cycle of an interval.
module mem_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       done
);

    logic [3:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != 4'd0)
            cnt <= cnt - 4'd1;
    end

    assign done = (cnt == 4'd0);

endmodule

// File: rtl/cmd_sequencer.sv
// Executes command frames against the cartridge SRAM, yielding the bus to the SNES,
// and returns one response byte per frame over a toggle handshake.
module cmd_sequencer
    import cmd_pkg::*;
#(
    parameter int ADDR_W   = 18,
    parameter int WAIT_CYC = 3,
    parameter int HOLD_CYC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_valid,
    input  logic [31:0]       cmd_frame,
    input  logic              snes_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              mem_oe,
    output logic              mem_ce_n,
    output logic              mem_we_n,
    output logic              mem_rd_n,
    output logic [7:0]        resp_byte,
    output logic              resp_toggle,
    output logic              busy,
    output logic              overrun
);

    state_t state, nxt;

    logic [OP_W-1:0]   op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;

    logic              is_wr, is_rd;
    logic              tmr_load, tmr_done;
    logic [3:0]        tmr_val;

    logic [ADDR_W-1:0] mem_addr_d;
    logic [7:0]        mem_wdata_d, resp_byte_d;
    logic              mem_oe_d, mem_ce_n_d, mem_we_n_d, mem_rd_n_d;
    logic              resp_toggle_d, busy_d, overrun_d;

    assign is_wr = (op_q == OP_WRITE);
    assign is_rd = (op_q == OP_READ);

    // Strobe interval is loaded in SETUP, hold interval on the last strobe cycle.
    assign tmr_load = (state == S_SETUP) || (state == S_STROBE && tmr_done);
    assign tmr_val  = (state == S_SETUP) ? 4'(WAIT_CYC - 1) : 4'(HOLD_CYC - 1);

    mem_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (state == S_STROBE || state == S_HOLD),
        .done     (tmr_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            state <= nxt;
            if (state == S_IDLE && frame_valid) begin
                op_q   <= cmd_frame[OP_LSB +: OP_W];
                addr_q <= cmd_frame[ADDR_LSB +: ADDR_W];
                data_q <= cmd_frame[DATA_LSB +: DATA_W];
            end
        end
    end

    // An idle bus lets DECODE start the access directly, so arbitration adds no cycle.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    if (frame_valid) nxt = S_DECODE;
            S_DECODE:  if (!op_is_access(op_q)) nxt = S_RESPOND;
                       else nxt = snes_busy ? S_ARB : S_SETUP;
            S_ARB:     if (!snes_busy) nxt = S_SETUP;
            S_SETUP:   nxt = S_STROBE;
            S_STROBE:  if (tmr_done) nxt = (HOLD_CYC > 0) ? S_HOLD : S_RESPOND;
            S_HOLD:    if (tmr_done) nxt = S_RESPOND;
            S_RESPOND: nxt = S_IDLE;
            default:   nxt = S_IDLE;
        endcase
    end

    // Outputs are computed from the next state and registered, keeping inputs off outputs.
    always_comb begin
        mem_addr_d    = mem_addr;
        mem_wdata_d   = mem_wdata;
        mem_ce_n_d    = 1'b1;
        mem_we_n_d    = 1'b1;
        mem_rd_n_d    = 1'b1;
        mem_oe_d      = 1'b0;
        resp_byte_d   = resp_byte;
        resp_toggle_d = resp_toggle;
        busy_d        = busy;
        overrun_d     = overrun;

        if (nxt == S_SETUP) begin
            mem_addr_d = addr_q;
            if (is_wr) mem_wdata_d = data_q;
        end
        if (nxt == S_SETUP || nxt == S_STROBE || nxt == S_HOLD) begin
            mem_ce_n_d = 1'b0;
            mem_oe_d   = is_wr;
        end
        if (nxt == S_STROBE) begin
            mem_we_n_d = !is_wr;
            mem_rd_n_d = !is_rd;
        end

        if (state == S_IDLE && frame_valid) busy_d = 1'b1;
        if (state == S_DECODE && op_q == OP_INIT) begin
            overrun_d   = 1'b0;
            resp_byte_d = RESP_INIT;
        end
        if (state == S_DECODE && !op_is_access(op_q) && op_q != OP_INIT)
            resp_byte_d = RESP_ILLEGAL;
        if (state == S_STROBE && tmr_done && is_rd) resp_byte_d = mem_rdata;
        if (state != S_DECODE && nxt == S_RESPOND && is_wr) resp_byte_d = RESP_WRITE;
        if (nxt == S_RESPOND) resp_toggle_d = !resp_toggle;
        if (state == S_RESPOND) busy_d = 1'b0;
        if (state != S_IDLE && frame_valid) overrun_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_oe      <= 1'b0;
            mem_ce_n    <= 1'b1;
            mem_we_n    <= 1'b1;
            mem_rd_n    <= 1'b1;
            resp_byte   <= 8'h00;
            resp_toggle <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            mem_addr    <= mem_addr_d;
            mem_wdata   <= mem_wdata_d;
            mem_oe      <= mem_oe_d;
            mem_ce_n    <= mem_ce_n_d;
            mem_we_n    <= mem_we_n_d;
            mem_rd_n    <= mem_rd_n_d;
            resp_byte   <= resp_byte_d;
            resp_toggle <= resp_toggle_d;
            busy        <= busy_d;
            overrun     <= overrun_d;
        end
    end

endmodule

// File: doc/cmd_sequencer.md
Name: cmd_sequencer

Overview:
- Executes 32-bit command frames delivered by the command-frame assembler and drives the cartridge SRAM bus.
- Arbitrates that bus against the SNES, which always has priority.
- Runs a timed write or read cycle per command.
- Returns one status/data byte to the host-side byte transmitter using a toggle handshake.

Parameters:
ADDR_W, 18, SRAM address width; frame layout fixes opcode 6 + ADDR_W + data 8 = 32
WAIT_CYC, 3, clk cycles the strobe is held active per access (1..15)
HOLD_CYC, 1, clk cycles of address/data hold after the strobe deasserts (0..3)

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
frame_valid  input  1  one-cycle pulse: cmd_frame is complete
cmd_frame  input  32  [31:26] opcode, [25:8] address, [7:0] data
snes_busy  input  1  SNES owns the cart bus while high
mem_addr  output  ADDR_W  SRAM address
mem_wdata  output  8  SRAM write data
mem_rdata  input  8  SRAM read data
mem_oe  output  1  drive enable for mem_wdata onto the shared bus
mem_ce_n  output  1  SRAM chip enable, active low
mem_we_n  output  1  SRAM write strobe, active low
mem_rd_n  output  1  SRAM output enable, active low
resp_byte  output  8  response byte
resp_toggle  output  1  inverts once per new resp_byte
busy  output  1  high from frame acceptance until the response is issued
overrun  output  1  sticky; a frame arrived while busy; cleared by INITIALIZE or rst

Behaviour:
- Reset values, applied asynchronously:
  - state IDLE
  - mem_addr 0, mem_wdata 0, mem_oe 0
  - mem_ce_n 1, mem_we_n 1, mem_rd_n 1
  - resp_byte 8'h00, resp_toggle 0, busy 0, overrun 0
- Opcodes: INIT 6'h00, WRITE 6'h01, READ 6'h02; any other value is illegal.
- IDLE:
  - On frame_valid, latch opcode, address and data into internal registers, set busy, go to DECODE.
  - A frame_valid in any state other than IDLE is dropped and sets overrun. The latched command is unaffected.
- DECODE (1 cycle):
  - INIT: clear overrun, resp_byte=8'hA5, go to RESPOND. The bus is not touched.
  - WRITE/READ: go to ARB.
  - Illegal opcode: resp_byte=8'hEE, go to RESPOND.
- ARB:
  - Wait while snes_busy=1. All bus outputs stay idle: ce_n/we_n/rd_n=1, mem_oe=0.
  - When snes_busy=0, go to SETUP.
- SETUP (1 cycle):
  - Drive mem_addr and assert mem_ce_n=0.
  - For WRITE, also drive mem_wdata and set mem_oe=1.
  - Go to STROBE with the wait counter loaded to WAIT_CYC-1.
- STROBE:
  - Hold mem_we_n=0 (WRITE) or mem_rd_n=0 (READ) for exactly WAIT_CYC cycles.
  - If snes_busy rises during SETUP or STROBE, the access completes anyway; the SNES side tolerates this bounded window.
  - On the last STROBE cycle, READ captures mem_rdata into resp_byte.
  - Deassert the strobe and go to HOLD.
- HOLD:
  - Lasts HOLD_CYC cycles; with HOLD_CYC=0 it is skipped.
  - Address, data and mem_ce_n are kept during HOLD.
  - Then release the bus (ce_n=1, oe=0) and go to RESPOND.
  - WRITE sets resp_byte=8'h5A.
- RESPOND (1 cycle):
  - Invert resp_toggle; resp_byte is stable from this cycle until the next response.
  - Clear busy, go to IDLE.
  - Latency from frame_valid to toggle: INIT/illegal = 2 cycles; WRITE/READ = 3+WAIT_CYC+HOLD_CYC+arbitration wait.
- Timing rules:
  - No combinational path from inputs to outputs.
  - mem_we_n and mem_rd_n are never both low.
  - Strobes are never asserted while ce_n=1.
- Reset asserted mid-access: all outputs return to reset values immediately and the access is aborted. No response is issued.
- Address wrap is not applicable: exactly one byte is accessed per command.

Decomposition:
- Package cmd_pkg: opcode localparams, response codes (A5/5A/EE), state encoding, frame field bit positions.
- These constants are shared with the frame assembler.
- One sub-module, mem_timer: loadable down-counter with a done flag, used for both the STROBE and HOLD intervals.

Test Plan:
- INIT frame 32'h00000000 -> resp_toggle flips 2 cycles after frame_valid; resp_byte=A5; bus untouched; overrun cleared.
- WRITE 32'h04_1234_C3 (op 01, addr 0x01234, data C3), snes_busy=0 -> ce_n low for 1+WAIT_CYC+HOLD_CYC cycles; we_n low exactly 3 cycles with addr=0x01234 and wdata=C3; resp_byte=5A.
- READ op 02 at addr 0x3FFFF, mem_rdata=7E -> rd_n low 3 cycles, we_n stays 1; resp_byte=7E; toggle flips once.
- WRITE with snes_busy held high 10 cycles -> no strobe and ce_n=1 throughout; access starts the cycle after snes_busy falls.
- Second frame_valid during STROBE -> overrun=1; first command completes normally; second command is never executed.
- Illegal op 6'h3F -> resp_byte=EE; rst pulsed during a READ's STROBE -> all outputs return to reset values and no toggle is issued.
